screen_controller: RTL and testbench
====================================

SCREEN_CONTROLLER -- requirements
Module: screen_controller

Interface
REQ-001 SHALL have parameter HIT_FRAMES, default 60, frames gameplay stays frozen after a player hit.
REQ-002 SHALL have parameter CLEAR_FRAMES, default 90, frames of pause after a wave is cleared.
REQ-003 SHALL have parameter OVER_FRAMES, default 120, minimum frames the game-over screen is held before a key is accepted.
REQ-004 SHALL have port Clk, input, 1, system clock; single clock domain.
REQ-005 SHALL have port Reset_n, input, 1, synchronous, active-low reset.
REQ-006 SHALL have port frame_clk, input, 1, VGA vertical-sync-derived frame strobe; asynchronous to Clk.
REQ-007 SHALL have port keycode, input, 8, current USB HID keycode; 8'h2C means space.
REQ-008 SHALL have port enemies_left, input, 6, live enemy count from the enemy block.
REQ-009 SHALL have port player_hit, input, 1, single-Clk pulse when an enemy bullet hits the player.
REQ-010 SHALL have port enemy_landed, input, 1, level signal, high when any enemy reaches the player row.
REQ-011 SHALL have outputs start (1), game_active (1), game_over (1), freeze (1), blink_on (1), round_reset (1), lives (2), level (3); these drive the color mapper and the sprite blocks.

Function
REQ-012 SHALL pass frame_clk through a 2-flop synchronizer; a frame tick is a one-Clk pulse on the synchronized rising edge.
REQ-013 SHALL generate a key press as a one-Clk pulse when keycode==8'h2C and it was not 8'h2C on the previous Clk; a held key produces one pulse.
REQ-014 SHALL implement states START, PLAY, HIT_PAUSE, LEVEL_CLEAR, GAME_OVER.
REQ-015 In START, on key press: lives<=3, level<=0, round_reset pulses for one Clk, go to PLAY.
REQ-016 In PLAY, priority (high to low): enemy_landed -> GAME_OVER; player_hit with lives==1 -> lives<=0, GAME_OVER; player_hit with lives>1 -> lives-1, HIT_PAUSE; enemies_left==0 -> LEVEL_CLEAR.
REQ-017 In HIT_PAUSE, count frame ticks; after HIT_FRAMES ticks return to PLAY; player_hit is ignored here.
REQ-018 In LEVEL_CLEAR, after CLEAR_FRAMES ticks: level<=level+1 saturating at 7, round_reset pulses one Clk, go to PLAY.
REQ-019 In GAME_OVER, key presses are ignored until OVER_FRAMES ticks have elapsed; the next key press then goes to START.
REQ-020 SHALL clear the frame counter on every state entry; the counter SHALL be wide enough for the largest parameter and SHALL not wrap.
REQ-021 SHALL register all outputs: start=1 only in START; game_active=1 in PLAY, HIT_PAUSE and LEVEL_CLEAR; freeze=1 in HIT_PAUSE and LEVEL_CLEAR; game_over=1 only in GAME_OVER.
REQ-022 A frame tick and a key press in the same Clk in GAME_OVER with the count reaching OVER_FRAMES on that tick SHALL NOT leave the state; the key must come on a later Clk.
REQ-023 lives SHALL never underflow below 0; level SHALL never exceed 7.

Reset
REQ-024 While Reset_n==0 at a Clk edge: state START, counter 0, lives 3, level 0, round_reset 0, start 1, game_active 0, freeze 0, game_over 0, blink_on 1, synchronizer and edge registers 0.
REQ-025 Reset asserted in any state, including mid-pause, SHALL abandon the operation with no round_reset pulse.

Configuration
REQ-026 With SCREEN_BLINK_EN defined, blink_on SHALL toggle every 32 frame ticks in START and GAME_OVER, and SHALL be forced to 1 on entry to those states and in all other states.
REQ-027 Without SCREEN_BLINK_EN, blink_on SHALL be constant 1 and no blink counter SHALL be synthesized.

Verification
REQ-028 Reset, then keycode 00->2C held 10 Clk -> exactly one round_reset pulse, start 0, game_active 1, lives 3.
REQ-029 In PLAY with lives 3, pulse player_hit -> lives 2, freeze 1 for exactly 60 frame ticks, then PLAY; a second player_hit during the pause leaves lives at 2.
REQ-030 In PLAY with lives 1, pulse player_hit together with enemies_left=0 -> GAME_OVER, lives 0; a key press at tick 50 is ignored, a key press after tick 120 -> START.
REQ-031 enemies_left=0 seven times in succession -> level 1..7 with one round_reset per clear; an eighth clear leaves level at 7.
REQ-032 With SCREEN_BLINK_EN in START -> blink_on toggles at ticks 32, 64, 96; rebuild without the macro -> blink_on stays 1.
REQ-033 Assert Reset_n=0 for one Clk at tick 40 of LEVEL_CLEAR -> START, level 0, no round_reset pulse.

Source files
------------

// File: rtl/screen_controller.sv
// Game screen sequencer: start / play / hit pause / level clear / game over, driven by frame ticks and space key.
// Optional SCREEN_BLINK_EN macro enables a 32-tick blink of blink_on on the start and game-over screens.
module screen_controller #(
    parameter int HIT_FRAMES   = 60,
    parameter int CLEAR_FRAMES = 90,
    parameter int OVER_FRAMES  = 120
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    input  logic [5:0] enemies_left,
    input  logic       player_hit,
    input  logic       enemy_landed,
    output logic       start,
    output logic       game_active,
    output logic       game_over,
    output logic       freeze,
    output logic       blink_on,
    output logic       round_reset,
    output logic [1:0] lives,
    output logic [2:0] level
);

    localparam int CNT_MAX_HC = (HIT_FRAMES > CLEAR_FRAMES) ? HIT_FRAMES : CLEAR_FRAMES;
    localparam int CNT_MAX    = (CNT_MAX_HC > OVER_FRAMES) ? CNT_MAX_HC : OVER_FRAMES;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] HIT_LAST   = CNT_W'(HIT_FRAMES - 1);
    localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_FRAMES - 1);
    localparam logic [CNT_W-1:0] OVER_MIN   = CNT_W'(OVER_FRAMES);
    localparam logic [CNT_W-1:0] CNT_TOP    = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_START,
        ST_PLAY,
        ST_HIT_PAUSE,
        ST_LEVEL_CLEAR,
        ST_GAME_OVER
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] frame_count, count_next;
    logic [1:0]       lives_next;
    logic [2:0]       level_next;
    logic             round_reset_next;

    logic frame_sync1, frame_sync2, frame_prev;
    logic key_prev;
    logic frame_tick, is_space, key_press;

    // frame_clk comes from the VGA domain, so it is double-flopped before edge detection
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            frame_sync1 <= 1'b0;
            frame_sync2 <= 1'b0;
            frame_prev  <= 1'b0;
            key_prev    <= 1'b0;
        end else begin
            frame_sync1 <= frame_clk;
            frame_sync2 <= frame_sync1;
            frame_prev  <= frame_sync2;
            key_prev    <= is_space;
        end
    end

    assign frame_tick = frame_sync2 & ~frame_prev;
    assign is_space   = (keycode == 8'h2C);
    assign key_press  = is_space & ~key_prev;

    always_comb begin
        state_next       = state;
        lives_next       = lives;
        level_next       = level;
        round_reset_next = 1'b0;
        case (state)
            ST_START: begin
                if (key_press) begin
                    lives_next       = 2'd3;
                    level_next       = 3'd0;
                    round_reset_next = 1'b1;
                    state_next       = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (enemy_landed) begin
                    state_next = ST_GAME_OVER;
                end else if (player_hit && lives <= 2'd1) begin
                    lives_next = 2'd0;
                    state_next = ST_GAME_OVER;
                end else if (player_hit) begin
                    lives_next = lives - 2'd1;
                    state_next = ST_HIT_PAUSE;
                end else if (enemies_left == 6'd0) begin
                    state_next = ST_LEVEL_CLEAR;
                end
            end
            ST_HIT_PAUSE: begin
                if (frame_tick && frame_count == HIT_LAST) begin
                    state_next = ST_PLAY;
                end
            end
            ST_LEVEL_CLEAR: begin
                if (frame_tick && frame_count == CLEAR_LAST) begin
                    level_next       = (level == 3'd7) ? level : level + 3'd1;
                    round_reset_next = 1'b1;
                    state_next       = ST_PLAY;
                end
            end
            ST_GAME_OVER: begin
                // uses the count from before this cycle's tick, so a key on the final tick is too early
                if (key_press && frame_count >= OVER_MIN) begin
                    state_next = ST_START;
                end
            end
            default: state_next = ST_START;
        endcase

        if (state_next != state) begin
            count_next = '0;
        end else if (frame_tick && frame_count != CNT_TOP) begin
            count_next = frame_count + CNT_ONE;
        end else begin
            count_next = frame_count;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state       <= ST_START;
            frame_count <= '0;
            lives       <= 2'd3;
            level       <= 3'd0;
            round_reset <= 1'b0;
            start       <= 1'b1;
            game_active <= 1'b0;
            freeze      <= 1'b0;
            game_over   <= 1'b0;
        end else begin
            state       <= state_next;
            frame_count <= count_next;
            lives       <= lives_next;
            level       <= level_next;
            round_reset <= round_reset_next;
            start       <= (state_next == ST_START);
            game_active <= (state_next inside {ST_PLAY, ST_HIT_PAUSE, ST_LEVEL_CLEAR});
            freeze      <= (state_next inside {ST_HIT_PAUSE, ST_LEVEL_CLEAR});
            game_over   <= (state_next == ST_GAME_OVER);
        end
    end

`ifdef SCREEN_BLINK_EN
    logic [4:0] blink_count;

    // blink restarts high on every entry into a title screen and is held high elsewhere
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            blink_count <= 5'd0;
            blink_on    <= 1'b1;
        end else if (state_next != state || !(state_next inside {ST_START, ST_GAME_OVER})) begin
            blink_count <= 5'd0;
            blink_on    <= 1'b1;
        end else if (frame_tick) begin
            blink_count <= blink_count + 5'd1;
            if (blink_count == 5'd31) begin
                blink_on <= ~blink_on;
            end
        end
    end
`else
    assign blink_on = 1'b1;
`endif

endmodule

// File: tb/tb_screen_controller.sv
// Directed self-checking bench for screen_controller; blink expectations follow SCREEN_BLINK_EN.
module tb_screen_controller;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       frame_clk = 1'b0;
    logic [7:0] keycode = 8'h00;
    logic [5:0] enemies_left = 6'd10;
    logic       player_hit = 1'b0;
    logic       enemy_landed = 1'b0;
    logic       start, game_active, game_over, freeze, blink_on, round_reset;
    logic [1:0] lives;
    logic [2:0] level;

    int check_count = 0;
    int pass_count  = 0;
    int rr_count    = 0;

    screen_controller dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .frame_clk    (frame_clk),
        .keycode      (keycode),
        .enemies_left (enemies_left),
        .player_hit   (player_hit),
        .enemy_landed (enemy_landed),
        .start        (start),
        .game_active  (game_active),
        .game_over    (game_over),
        .freeze       (freeze),
        .blink_on     (blink_on),
        .round_reset  (round_reset),
        .lives        (lives),
        .level        (level)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        #1;
        if (round_reset) rr_count++;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic frame_tick();
        frame_clk = 1'b1;
        wait_clks(4);
        frame_clk = 1'b0;
        wait_clks(4);
    endtask

    task automatic ticks(input int n);
        repeat (n) frame_tick();
    endtask

    task automatic press_key();
        keycode = 8'h2C;
        wait_clks(1);
        keycode = 8'h00;
        wait_clks(1);
    endtask

    task automatic pulse_hit();
        player_hit = 1'b1;
        wait_clks(1);
        player_hit = 1'b0;
        wait_clks(1);
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        wait_clks(3);
        check_count++; if (start !== 1'b1) $display("[TB] FAIL reset_start: got %b expected 1", start); else pass_count++;
        check_count++; if (game_active !== 1'b0) $display("[TB] FAIL reset_game_active: got %b expected 0", game_active); else pass_count++;
        check_count++; if (freeze !== 1'b0) $display("[TB] FAIL reset_freeze: got %b expected 0", freeze); else pass_count++;
        check_count++; if (game_over !== 1'b0) $display("[TB] FAIL reset_game_over: got %b expected 0", game_over); else pass_count++;
        check_count++; if (lives !== 2'd3) $display("[TB] FAIL reset_lives: got %0d expected 3", lives); else pass_count++;
        check_count++; if (level !== 3'd0) $display("[TB] FAIL reset_level: got %0d expected 0", level); else pass_count++;
        check_count++; if (round_reset !== 1'b0) $display("[TB] FAIL reset_round_reset: got %b expected 0", round_reset); else pass_count++;
        check_count++; if (blink_on !== 1'b1) $display("[TB] FAIL reset_blink_on: got %b expected 1", blink_on); else pass_count++;
        Reset_n = 1'b1;
        wait_clks(2);
    endtask

    task automatic test_start();
        int rr0;
        rr0 = rr_count;
        keycode = 8'h2C;
        wait_clks(10);
        keycode = 8'h00;
        wait_clks(2);
        check_count++; if (rr_count - rr0 !== 1) $display("[TB] FAIL start_round_reset_pulses: got %0d expected 1", rr_count - rr0); else pass_count++;
        check_count++; if (start !== 1'b0) $display("[TB] FAIL start_start: got %b expected 0", start); else pass_count++;
        check_count++; if (game_active !== 1'b1) $display("[TB] FAIL start_game_active: got %b expected 1", game_active); else pass_count++;
        check_count++; if (lives !== 2'd3) $display("[TB] FAIL start_lives: got %0d expected 3", lives); else pass_count++;
        check_count++; if (level !== 3'd0) $display("[TB] FAIL start_level: got %0d expected 0", level); else pass_count++;
    endtask

    task automatic test_hit_pause();
        pulse_hit();
        check_count++; if (lives !== 2'd2) $display("[TB] FAIL hit_lives: got %0d expected 2", lives); else pass_count++;
        check_count++; if (freeze !== 1'b1) $display("[TB] FAIL hit_freeze_entry: got %b expected 1", freeze); else pass_count++;
        for (int i = 1; i <= 59; i++) begin
            frame_tick();
            if (i == 30) pulse_hit();
        end
        check_count++; if (freeze !== 1'b1) $display("[TB] FAIL hit_freeze_tick59: got %b expected 1", freeze); else pass_count++;
        check_count++; if (lives !== 2'd2) $display("[TB] FAIL hit_ignored_in_pause: got %0d expected 2", lives); else pass_count++;
        frame_tick();
        check_count++; if (freeze !== 1'b0) $display("[TB] FAIL hit_freeze_tick60: got %b expected 0", freeze); else pass_count++;
        check_count++; if (game_active !== 1'b1) $display("[TB] FAIL hit_back_to_play: got %b expected 1", game_active); else pass_count++;
    endtask

    task automatic test_level_clear();
        int rr0;
        int exp_level;
        for (int i = 1; i <= 8; i++) begin
            rr0 = rr_count;
            exp_level = (i > 7) ? 7 : i;
            enemies_left = 6'd0;
            wait_clks(1);
            enemies_left = 6'd10;
            wait_clks(1);
            ticks(89);
            check_count++; if (freeze !== 1'b1) $display("[TB] FAIL clear%0d_freeze_tick89: got %b expected 1", i, freeze); else pass_count++;
            frame_tick();
            check_count++; if (level !== 3'(exp_level)) $display("[TB] FAIL clear%0d_level: got %0d expected %0d", i, level, exp_level); else pass_count++;
            check_count++; if (rr_count - rr0 !== 1) $display("[TB] FAIL clear%0d_round_reset: got %0d expected 1", i, rr_count - rr0); else pass_count++;
            check_count++; if (freeze !== 1'b0) $display("[TB] FAIL clear%0d_freeze_done: got %b expected 0", i, freeze); else pass_count++;
        end
    endtask

    task automatic test_reset_mid_clear();
        int rr0;
        rr0 = rr_count;
        enemies_left = 6'd0;
        wait_clks(1);
        enemies_left = 6'd10;
        wait_clks(1);
        ticks(40);
        check_count++; if (freeze !== 1'b1) $display("[TB] FAIL midclear_freeze: got %b expected 1", freeze); else pass_count++;
        Reset_n = 1'b0;
        wait_clks(1);
        Reset_n = 1'b1;
        wait_clks(3);
        check_count++; if (start !== 1'b1) $display("[TB] FAIL midclear_start: got %b expected 1", start); else pass_count++;
        check_count++; if (level !== 3'd0) $display("[TB] FAIL midclear_level: got %0d expected 0", level); else pass_count++;
        check_count++; if (freeze !== 1'b0) $display("[TB] FAIL midclear_freeze_after: got %b expected 0", freeze); else pass_count++;
        check_count++; if (rr_count - rr0 !== 0) $display("[TB] FAIL midclear_round_reset: got %0d expected 0", rr_count - rr0); else pass_count++;
    endtask

    task automatic test_game_over();
        pulse_hit();
        ticks(60);
        check_count++; if (lives !== 2'd2 || freeze !== 1'b0) $display("[TB] FAIL go_first_hit: got lives %0d freeze %b expected 2 0", lives, freeze); else pass_count++;
        pulse_hit();
        ticks(60);
        check_count++; if (lives !== 2'd1 || freeze !== 1'b0) $display("[TB] FAIL go_second_hit: got lives %0d freeze %b expected 1 0", lives, freeze); else pass_count++;
        player_hit = 1'b1;
        enemies_left = 6'd0;
        wait_clks(1);
        player_hit = 1'b0;
        enemies_left = 6'd10;
        wait_clks(1);
        check_count++; if (game_over !== 1'b1) $display("[TB] FAIL go_enter: got %b expected 1", game_over); else pass_count++;
        check_count++; if (lives !== 2'd0) $display("[TB] FAIL go_lives: got %0d expected 0", lives); else pass_count++;
        check_count++; if (game_active !== 1'b0 || freeze !== 1'b0) $display("[TB] FAIL go_active_freeze: got %b %b expected 0 0", game_active, freeze); else pass_count++;
        ticks(50);
        press_key();
        check_count++; if (game_over !== 1'b1) $display("[TB] FAIL go_key_tick50: got %b expected 1", game_over); else pass_count++;
        ticks(69);
        frame_clk = 1'b1;
        wait_clks(2);
        keycode = 8'h2C;
        wait_clks(2);
        frame_clk = 1'b0;
        keycode = 8'h00;
        wait_clks(4);
        check_count++; if (game_over !== 1'b1) $display("[TB] FAIL go_key_same_tick120: got %b expected 1", game_over); else pass_count++;
        press_key();
        check_count++; if (start !== 1'b1 || game_over !== 1'b0) $display("[TB] FAIL go_key_after120: got start %b game_over %b expected 1 0", start, game_over); else pass_count++;
    endtask

    task automatic test_blink();
        logic exp_blink;
        check_count++; if (blink_on !== 1'b1) $display("[TB] FAIL blink_entry: got %b expected 1", blink_on); else pass_count++;
        for (int i = 1; i <= 96; i++) begin
            frame_tick();
`ifdef SCREEN_BLINK_EN
            exp_blink = ((i / 32) % 2 == 0);
`else
            exp_blink = 1'b1;
`endif
            if (i == 31 || i == 32 || i == 33 || i == 63 || i == 64 || i == 96) begin
                check_count++; if (blink_on !== exp_blink) $display("[TB] FAIL blink_tick%0d: got %b expected %b", i, blink_on, exp_blink); else pass_count++;
            end
        end
    endtask

    task automatic test_enemy_landed();
        press_key();
        check_count++; if (game_active !== 1'b1) $display("[TB] FAIL landed_play: got %b expected 1", game_active); else pass_count++;
        enemy_landed = 1'b1;
        player_hit = 1'b1;
        wait_clks(1);
        enemy_landed = 1'b0;
        player_hit = 1'b0;
        wait_clks(1);
        check_count++; if (game_over !== 1'b1 || lives !== 2'd3) $display("[TB] FAIL landed_game_over: got game_over %b lives %0d expected 1 3", game_over, lives); else pass_count++;
    endtask

    initial begin
        $display("[TB] screen_controller bench start");
        test_reset();
        test_start();
        test_hit_pause();
        test_level_clear();
        test_reset_mid_clear();
        test_start();
        test_game_over();
        test_blink();
        test_enemy_landed();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
